// File: rtl/cam_i2c_arbiter.sv
// Lets several camera configuration requesters share one uii2c master.
// One owner at a time; done/err pulses are routed back to that owner.
module cam_i2c_arbiter #(
    parameter int          N_REQ   = 3,
    parameter bit          RR_EN   = 1'b1,
    parameter logic [15:0] TIMEOUT = 16'd4095
) (
    input  logic                I_clk,
    input  logic                I_rst_n,
    input  logic [N_REQ-1:0]    I_req,
    input  logic [32*N_REQ-1:0] I_wr_data,
    input  logic [8*N_REQ-1:0]  I_wr_cnt,
    output logic [N_REQ-1:0]    O_grant,
    output logic [N_REQ-1:0]    O_done,
    output logic [N_REQ-1:0]    O_err,
    output logic                O_busy,
    output logic                O_iic_req,
    output logic [31:0]         O_iic_wr_data,
    output logic [7:0]          O_iic_wr_cnt,
    input  logic                I_iic_busy,
    input  logic                I_iic_bus_error
);

    // state   | meaning
    // S_IDLE  | no owner; arbitrate when a request is up and the bus is quiet
    // S_ISSUE | O_iic_req high, waiting for uii2c busy (timeout counted here)
    // S_WAIT  | uii2c running the frame; bus errors are collected
    // S_DONE  | one cycle: done/err pulse to the owner, grant still visible

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_REQ-1:0]   r_grant,    w_grant_nxt;
    logic [N_REQ-1:0]   r_done,     w_done_nxt;
    logic [N_REQ-1:0]   r_err,      w_err_nxt;
    logic               r_iic_req,  w_iic_req_nxt;
    logic [31:0]        r_wr_data,  w_wr_data_nxt;
    logic [7:0]         r_wr_cnt,   w_wr_cnt_nxt;
    logic [PW-1:0]      r_ptr,      w_ptr_nxt;
    logic [PW-1:0]      r_gidx,     w_gidx_nxt;
    logic [15:0]        r_cnt,      w_cnt_nxt;
    logic               r_flag,     w_flag_nxt;

    logic               w_win_vld;
    logic [PW-1:0]      w_win_idx;
    logic [31:0]        w_win_data;
    logic [7:0]         w_win_cnt;
    logic [15:0]        w_cnt_inc;
    logic               w_flag_now;

    function automatic logic [PW-1:0] f_wrap(input int v);
        int w;
        w = (v >= N_REQ) ? v - N_REQ : v;
        return w[PW-1:0];
    endfunction

    // Round-robin searches upward from the slot after the last owner.
    always_comb begin
        w_win_vld  = 1'b0;
        w_win_idx  = '0;
        w_win_data = '0;
        w_win_cnt  = '0;
        for (int o = 1; o <= N_REQ; o++) begin
            if (RR_EN) begin
                if (!w_win_vld && I_req[f_wrap(int'(r_ptr) + o)]) begin
                    w_win_vld = 1'b1;
                    w_win_idx = f_wrap(int'(r_ptr) + o);
                end
            end else begin
                if (!w_win_vld && I_req[o-1]) begin
                    w_win_vld = 1'b1;
                    w_win_idx = PW'(o - 1);
                end
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win_idx == PW'(i)) begin
                w_win_data = I_wr_data[32*i +: 32];
                w_win_cnt  = I_wr_cnt[8*i +: 8];
            end
        end
    end

    assign w_cnt_inc  = r_cnt + 16'd1;
    assign w_flag_now = r_flag | I_iic_bus_error;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_done_nxt    = '0;
        w_err_nxt     = '0;
        w_iic_req_nxt = r_iic_req;
        w_wr_data_nxt = r_wr_data;
        w_wr_cnt_nxt  = r_wr_cnt;
        w_ptr_nxt     = r_ptr;
        w_gidx_nxt    = r_gidx;
        w_cnt_nxt     = r_cnt;
        w_flag_nxt    = r_flag;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld && !I_iic_busy) begin
                    w_grant_nxt            = '0;
                    w_grant_nxt[w_win_idx] = 1'b1;
                    w_gidx_nxt             = w_win_idx;
                    w_wr_data_nxt          = w_win_data;
                    w_wr_cnt_nxt           = w_win_cnt;
                    w_iic_req_nxt          = 1'b1;
                    w_cnt_nxt              = '0;
                    w_flag_nxt             = 1'b0;
                    w_state_nxt            = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt_nxt = w_cnt_inc;
                if (I_iic_busy) begin
                    w_iic_req_nxt = 1'b0;
                    w_state_nxt   = S_WAIT;
                end else if (w_cnt_inc == TIMEOUT) begin
                    w_iic_req_nxt = 1'b0;
                    w_flag_nxt    = 1'b1;
                    w_done_nxt    = r_grant;
                    w_err_nxt     = r_grant;
                    w_ptr_nxt     = r_gidx;
                    w_state_nxt   = S_DONE;
                end
            end
            S_WAIT: begin
                w_flag_nxt = w_flag_now;
                if (!I_iic_busy) begin
                    w_done_nxt  = r_grant;
                    w_err_nxt   = w_flag_now ? r_grant : '0;
                    w_ptr_nxt   = r_gidx;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_grant_nxt = '0;
                w_flag_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_iic_req <= 1'b0;
            r_wr_data <= '0;
            r_wr_cnt  <= '0;
            r_ptr     <= PW'(N_REQ - 1);
            r_gidx    <= '0;
            r_cnt     <= '0;
            r_flag    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_iic_req <= w_iic_req_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_wr_cnt  <= w_wr_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gidx    <= w_gidx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_flag    <= w_flag_nxt;
        end
    end

    assign O_grant       = r_grant;
    assign O_done        = r_done;
    assign O_err         = r_err;
    assign O_busy        = (r_state != S_IDLE);
    assign O_iic_req     = r_iic_req;
    assign O_iic_wr_data = r_wr_data;
    assign O_iic_wr_cnt  = r_wr_cnt;

endmodule

// File: tb/tb_cam_i2c_arbiter.sv
// Bench for cam_i2c_arbiter: a round-robin and a fixed-priority instance, each with
// a transaction-timestamp reference model and a scripted uii2c busy responder.
module tb_cam_i2c_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req     [2];
    logic [95:0] wd      [2];
    logic [23:0] wc      [2];
    logic [2:0]  grant   [2];
    logic [2:0]  done    [2];
    logic [2:0]  err     [2];
    logic [31:0] iic_wd  [2];
    logic [7:0]  iic_wc  [2];
    logic [1:0]  busy_o;
    logic [1:0]  iic_req_o;
    logic [1:0]  mbusy;
    logic [1:0]  berr;
    logic        ext_busy;
    logic [1:0]  iic_busy;

    assign iic_busy = mbusy | {2{ext_busy}};

    always #5 clk = ~clk;

    cam_i2c_arbiter #(.N_REQ(3), .RR_EN(1'b1), .TIMEOUT(16'(TO))) u_rr (
        .I_clk(clk), .I_rst_n(rst_n), .I_req(req[0]), .I_wr_data(wd[0]), .I_wr_cnt(wc[0]),
        .O_grant(grant[0]), .O_done(done[0]), .O_err(err[0]), .O_busy(busy_o[0]),
        .O_iic_req(iic_req_o[0]), .O_iic_wr_data(iic_wd[0]), .O_iic_wr_cnt(iic_wc[0]),
        .I_iic_busy(iic_busy[0]), .I_iic_bus_error(berr[0]));

    cam_i2c_arbiter #(.N_REQ(3), .RR_EN(1'b0), .TIMEOUT(16'(TO))) u_fp (
        .I_clk(clk), .I_rst_n(rst_n), .I_req(req[1]), .I_wr_data(wd[1]), .I_wr_cnt(wc[1]),
        .O_grant(grant[1]), .O_done(done[1]), .O_err(err[1]), .O_busy(busy_o[1]),
        .O_iic_req(iic_req_o[1]), .O_iic_wr_data(iic_wd[1]), .O_iic_wr_cnt(iic_wc[1]),
        .I_iic_busy(iic_busy[1]), .I_iic_bus_error(berr[1]));

    int nassert = 0;
    int nfail   = 0;
    int cyc     = 0;

    // Reference model: one record per transaction, expressed as cycle timestamps.
    bit          act   [2];
    int          tg    [2];
    int          tre   [2];
    int          td    [2];
    int          tfree [2];
    int          ptr   [2];
    int          pend  [2];
    int          tbr   [2];
    int          tbf   [2];
    int          terr_at [2];
    bit          terr  [2];
    logic [2:0]  own   [2];
    logic [31:0] efr   [2];
    logic [7:0]  ecnt  [2];
    logic [2:0]  prev_grant [2];
    logic [2:0]  last_done  [2];
    logic [2:0]  last_err   [2];
    int          reqhi [2];
    int          obs_order [2][$];

    int pD = 2, pL = 4, perr = -1;
    bit pnever = 1'b0, rnd_params = 1'b0, keep = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int p, input bit rr);
        if (rr) begin
            for (int o = 1; o <= 3; o++) if (r[(p + o) % 3]) return (p + o) % 3;
        end else begin
            for (int i = 0; i < 3; i++) if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            act[d] = 1'b0; ptr[d] = 2; tfree[d] = 0; own[d] = '0;
            efr[d] = '0; ecnt[d] = '0; mbusy[d] = 1'b0; berr[d] = 1'b0;
            prev_grant[d] = '0;
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s grant d%0d", tag, d), 32'(grant[d]), 32'd0);
            chk($sformatf("%s done d%0d", tag, d), 32'(done[d]), 32'd0);
            chk($sformatf("%s err d%0d", tag, d), 32'(err[d]), 32'd0);
            chk($sformatf("%s busy d%0d", tag, d), 32'(busy_o[d]), 32'd0);
            chk($sformatf("%s iic_req d%0d", tag, d), 32'(iic_req_o[d]), 32'd0);
            chk($sformatf("%s wr_data d%0d", tag, d), iic_wd[d], 32'd0);
            chk($sformatf("%s wr_cnt d%0d", tag, d), 32'(iic_wc[d]), 32'd0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            int w;
            int gi;
            logic [2:0] eg, ed, ee;
            gi = -1;
            for (int i = 0; i < 3; i++) if (grant[d][i]) gi = i;
            if (grant[d] != 3'b000 && prev_grant[d] == 3'b000) obs_order[d].push_back(gi);
            prev_grant[d] = grant[d];
            if (!act[d] && cyc >= tfree[d] && req[d] != 3'b000 && !iic_busy[d]) begin
                w = pick(req[d], ptr[d], d == 0);
                act[d] = 1'b1; tg[d] = cyc; own[d] = 3'b001 << w; pend[d] = w;
                efr[d] = wd[d][w*32 +: 32]; ecnt[d] = wc[d][w*8 +: 8];
                if (rnd_params) begin
                    pnever = ($urandom_range(0, 7) == 0);
                    pD = $urandom_range(1, 4);
                    pL = $urandom_range(1, 12);
                    perr = (pL >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(0, pL - 2) : -1;
                end
                if (pnever) begin
                    tre[d] = cyc + TO - 1; td[d] = cyc + TO;
                    tbr[d] = -1; tbf[d] = -2; terr_at[d] = -1; terr[d] = 1'b1;
                end else begin
                    tre[d] = cyc + pD - 1; tbr[d] = cyc + pD - 1;
                    tbf[d] = cyc + pD + pL - 2; td[d] = cyc + pD + pL;
                    terr_at[d] = (perr >= 0) ? cyc + pD + perr : -1;
                    terr[d] = (perr >= 0);
                end
            end
            eg = act[d] ? own[d] : 3'b000;
            ed = (act[d] && cyc == td[d]) ? own[d] : 3'b000;
            ee = (act[d] && cyc == td[d] && terr[d]) ? own[d] : 3'b000;
            chk($sformatf("grant d%0d c%0d", d, cyc), 32'(grant[d]), 32'(eg));
            chk($sformatf("done d%0d c%0d", d, cyc), 32'(done[d]), 32'(ed));
            chk($sformatf("err d%0d c%0d", d, cyc), 32'(err[d]), 32'(ee));
            chk($sformatf("iic_req d%0d c%0d", d, cyc), 32'(iic_req_o[d]), 32'(act[d] && cyc <= tre[d]));
            chk($sformatf("busy d%0d c%0d", d, cyc), 32'(busy_o[d]), 32'(act[d]));
            chk($sformatf("wr_data d%0d c%0d", d, cyc), iic_wd[d], efr[d]);
            chk($sformatf("wr_cnt d%0d c%0d", d, cyc), 32'(iic_wc[d]), 32'(ecnt[d]));
            reqhi[d] += int'(iic_req_o[d]);
            if (done[d] != 3'b000) begin
                last_done[d] = done[d];
                last_err[d]  = err[d];
            end
            if (act[d] && cyc == td[d]) begin
                act[d] = 1'b0; ptr[d] = pend[d]; tfree[d] = cyc + 2;
                if (!keep) req[d][pend[d]] = 1'b0;
            end
            mbusy[d] = act[d] && cyc >= tbr[d] && cyc <= tbf[d];
            berr[d]  = act[d] && cyc == terr_at[d];
        end
    endtask

    task automatic drain(input string tag, input int maxc);
        int n = 0;
        while ((act[0] || act[1] || req[0] != 3'b000 || req[1] != 3'b000) && n < maxc) begin
            step();
            n++;
        end
        chk({tag, " drain bound"}, 32'(n < maxc), 32'd1);
        step();
        step();
    endtask

    task automatic set_req(input int idx, input logic [31:0] frame, input logic [7:0] cnt);
        for (int d = 0; d < 2; d++) begin
            wd[d][idx*32 +: 32] = frame;
            wc[d][idx*8 +: 8]   = cnt;
            req[d][idx]         = 1'b1;
            reqhi[d]            = 0;
            last_done[d]        = '0;
            last_err[d]         = '0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b1; ext_busy = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; wd[d] = '0; wc[d] = '0; reqhi[d] = 0;
            last_done[d] = '0; last_err[d] = '0;
        end
        model_reset();
        #1 rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Contention: all three held high continuously.
        pD = 1; pL = 3; pnever = 1'b0; perr = -1; keep = 1'b1;
        for (int d = 0; d < 2; d++) begin
            wd[d] = {32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
            wc[d] = {8'd4, 8'd3, 8'd2};
            req[d] = 3'b111;
            obs_order[d].delete();
        end
        n = 0;
        while ((obs_order[0].size() < 6 || obs_order[1].size() < 6) && n < 300) begin
            step();
            n++;
        end
        chk("contention bound", 32'(n < 300), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr order %0d", i), 32'(obs_order[0][i]), 32'(i % 3));
            chk($sformatf("fp order %0d", i), 32'(obs_order[1][i]), 32'd0);
        end
        keep = 1'b0;
        drain("contention", 400);

        // Single request, busy after 2 cycles for 100 cycles.
        pD = 2; pL = 100;
        set_req(0, 32'h000A3034, 8'd4);
        drain("single", 300);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("single iic_req cycles d%0d", d), 32'(reqhi[d]), 32'd2);
            chk($sformatf("single done d%0d", d), 32'(last_done[d]), 32'b001);
            chk($sformatf("single err d%0d", d), 32'(last_err[d]), 32'b000);
            chk($sformatf("single wr_data hold d%0d", d), iic_wd[d], 32'h000A3034);
        end

        // Timeout: busy never rises.
        pnever = 1'b1;
        set_req(1, 32'h00123456, 8'd3);
        drain("timeout", 100);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("timeout iic_req cycles d%0d", d), 32'(reqhi[d]), 32'(TO));
            chk($sformatf("timeout done d%0d", d), 32'(last_done[d]), 32'b010);
            chk($sformatf("timeout err d%0d", d), 32'(last_err[d]), 32'b010);
        end
        pnever = 1'b0;

        // Bus error during WAIT, then a clean transaction from the same requester.
        pD = 2; pL = 10; perr = 3;
        set_req(2, 32'h0055AA30, 8'd4);
        drain("buserr", 100);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("buserr done d%0d", d), 32'(last_done[d]), 32'b100);
            chk($sformatf("buserr err d%0d", d), 32'(last_err[d]), 32'b100);
        end
        perr = -1;
        set_req(2, 32'h0066BB30, 8'd4);
        drain("after buserr", 100);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("clean done d%0d", d), 32'(last_done[d]), 32'b100);
            chk($sformatf("clean err d%0d", d), 32'(last_err[d]), 32'b000);
        end

        // Bus already busy when a request arrives.
        pD = 2; pL = 4;
        ext_busy = 1'b1;
        step();
        set_req(1, 32'h00778830, 8'd2);
        repeat (6) step();
        for (int d = 0; d < 2; d++)
            chk($sformatf("busy idle no grant d%0d", d), 32'(grant[d]), 32'd0);
        ext_busy = 1'b0;
        step();
        for (int d = 0; d < 2; d++)
            chk($sformatf("busy idle grant d%0d", d), 32'(grant[d]), 32'b010);
        drain("busy idle", 100);

        // Reset during WAIT, then all three request.
        pD = 2; pL = 20;
        set_req(1, 32'h00999930, 8'd4);
        n = 0;
        while (!(act[0] && cyc == tg[0] + 4) && n < 50) begin
            step();
            n++;
        end
        chk("reset wait bound", 32'(n < 50), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero("mid reset");
        model_reset();
        for (int d = 0; d < 2; d++) req[d] = 3'b000;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        pD = 1; pL = 2;
        for (int d = 0; d < 2; d++) req[d] = 3'b111;
        step();
        for (int d = 0; d < 2; d++)
            chk($sformatf("post reset grant d%0d", d), 32'(grant[d]), 32'b001);
        drain("post reset", 200);

        // Randomized traffic.
        rnd_params = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 3; i++) begin
                    if (!req[d][i] && $urandom_range(0, 5) == 0) begin
                        wd[d][i*32 +: 32] = $urandom;
                        wc[d][i*8 +: 8]   = 8'($urandom_range(1, 4));
                        req[d][i]         = 1'b1;
                    end
                end
            end
            step();
        end
        drain("random", 600);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
